siso_shift_register: RTL and testbench
======================================

// Module: siso_shift_register
//
// PURPOSE
// - Serial-in/serial-out shift register: delays a 1-bit serial stream by exactly N clock cycles.
// - Generic delay-line / serializer building block in the Shift_Register library.
// - Pure datapath: no handshake and no enable. Shifts on every rising clock edge.
//
// PARAMETERS
// - N   default 4   register depth in bits (= latency in cycles); legal range N >= 1
//
// PORTS
// - clk         input   1   single clock; all state updates on its rising edge
// - rst         input   1   asynchronous, active-low reset (0 = reset asserted)
// - serial_in   input   1   serial data in; sampled at each rising clk edge
// - serial_out  output  1   serial data out; equal to shift_reg[N-1]
//
// BEHAVIOUR
// - Clocking and reset (already decided): one clock, clk.
//   - rst is asynchronous and active-low.
// - State: internal register shift_reg[N-1:0].
//   - The name is fixed; benches probe it hierarchically (dut.shift_reg).
// - Reset:
//   - rst=0 clears shift_reg to all zeros immediately, without waiting for a clk edge.
//   - serial_out=0 while rst=0.
//   - While rst=0, clk edges have no effect.
// - Shift (rst=1), every rising clk edge:
//   - N>=2: shift_reg <= {shift_reg[N-2:0], serial_in}. LSB is the entry point; MSB is the exit.
//   - N==1: shift_reg <= serial_in.
// - Output:
//   - serial_out = shift_reg[N-1] (registered, no combinational path from serial_in).
//   - It changes only on a clk rising edge or on rst assertion.
// - Latency:
//   - A bit sampled at edge k appears on serial_out after edge k+N-1.
//   - It is held until edge k+N.
//   - Net delay is N cycles, measured from the edge on which the bit was driven to the edge on which it leaves.
// - Boundary conditions:
//   - Reset mid-stream: all in-flight bits are discarded. The register refills with zeros and fresh input after release.
//   - Reset release: the release is asynchronous. Edges occurring after release shift normally.
//   - Reset release coincident with a clk edge: that edge may or may not shift. Benches change rst on the negedge.
//   - X/Z on serial_in: propagates through the register unchanged. There is no filtering.
// - No other outputs, counters or flags exist in the base build.
//
// CONFIGURATION
// - Macro SISO_PAR_OUT_EN.
// - When defined:
//   - Adds output port parallel_out [N-1:0], equal to shift_reg.
//   - parallel_out is registered. It resets to 0 asynchronously with rst.
//   - Intended for debug and for SIPO reuse.
// - When undefined:
//   - The port is absent.
//   - The port list is exactly clk, rst, serial_in, serial_out.
// - serial_out behaviour is identical in both builds.
//
// TESTING (N=4, stimulus applied on the clk negedge, checks made 1 ns after the posedge)
// - Reset: hold rst=0 for 2 cycles.
//   -> shift_reg=0000, serial_out=0 throughout, regardless of serial_in.
// - Pattern 1,0,1,0 after rst=1, one bit per cycle.
//   -> shift_reg = 0001, 0010, 0101, 1010.
//   -> serial_out = 0, 0, 0, 1.
// - Flush: continue with serial_in=0 for 4 cycles.
//   -> shift_reg = 0100, 1000, 0000, 0000.
//   -> serial_out = 0, 1, 0, 0 (original stream emerges in order).
// - Async reset mid-stream: load 1111, then drive rst=0 between clk edges.
//   -> shift_reg=0000 and serial_out=0 before the next posedge.
// - Latency: single 1 pulse on serial_in, otherwise 0.
//   -> serial_out is high for exactly one cycle, N cycles after the pulse was driven.
// - N=1 build: serial_in pattern 1,0,1.
//   -> serial_out = 1,0,1, delayed by one edge.
//   - With SISO_PAR_OUT_EN defined: parallel_out always equals shift_reg.

Source files
------------

// File: rtl/siso_shift_register.sv
// Serial-in/serial-out delay line of N cycles; LSB is the entry point, MSB the exit.
// Optional macro SISO_PAR_OUT_EN exposes the whole register as parallel_out.
module siso_shift_register #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         serial_in,
  output logic         serial_out
`ifdef SISO_PAR_OUT_EN
  ,
  output logic [N-1:0] parallel_out
`endif
);

  logic [N-1:0] shift_reg;
  logic [N-1:0] shift_reg_d;

  // A depth of one has no lower slice to carry forward, so it needs its own next-state form.
  if (N == 1) begin : g_depth_one
    always_comb begin
      shift_reg_d = serial_in;
    end
  end else begin : g_depth_multi
    always_comb begin
      shift_reg_d = {shift_reg[N-2:0], serial_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
    end else begin
      shift_reg <= shift_reg_d;
    end
  end

  assign serial_out = shift_reg[N-1];

`ifdef SISO_PAR_OUT_EN
  assign parallel_out = shift_reg;
`endif

endmodule

// File: tb/tb_siso_shift_register.sv
// Self-checking bench: N=4 and N=1 instances against a history-queue model plus directed literals.
// Build with SISO_PAR_OUT_EN defined to also check parallel_out.
module tb_siso_shift_register;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serial_in = 1'b1;
  logic out4;
  logic out1;
`ifdef SISO_PAR_OUT_EN
  logic [3:0] par4;
  logic [0:0] par1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  siso_shift_register #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .serial_out (out4)
`ifdef SISO_PAR_OUT_EN
    ,
    .parallel_out (par4)
`endif
  );

  siso_shift_register #(.N(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .serial_out (out1)
`ifdef SISO_PAR_OUT_EN
    ,
    .parallel_out (par1)
`endif
  );

  // Model: every accepted bit, newest first; reset forgets all of them.
  logic hist[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist.delete();
    end else begin
      hist.push_front(serial_in);
      if (hist.size() > 8) void'(hist.pop_back());
    end
  end

  // Bit i of the register holds the input accepted i edges ago (zero if none since reset).
  function automatic logic [3:0] model_reg(input int depth);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < depth; i++) begin
      if (i < hist.size()) r[i] = hist[i];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    logic [3:0] e4;
    logic [3:0] e1;
    #1;
    e4 = model_reg(4);
    e1 = model_reg(1);
    chk("model_reg4", dut.shift_reg, e4);
    chk("model_out4", {3'b0, out4}, {3'b0, e4[3]});
    chk("model_reg1", {3'b0, dut1.shift_reg}, e1);
    chk("model_out1", {3'b0, out1}, e1);
`ifdef SISO_PAR_OUT_EN
    chk("model_par4", par4, e4);
    chk("model_par1", {3'b0, par1}, e1);
`endif
  end

  task automatic step(input logic b);
    @(negedge clk);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] pat_reg  [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};
  logic       pat_out  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       pat_bits [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] fl_reg   [4] = '{4'b0100, 4'b1000, 4'b0000, 4'b0000};
  logic       fl_out   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic       lat_out  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    // Reset held two cycles with serial_in toggling; nothing may enter.
    @(posedge clk); #1;
    chk("rst_reg_c0", dut.shift_reg, 4'b0000);
    chk("rst_out_c0", {3'b0, out4}, 4'b0000);
    step(1'b0);
    chk("rst_reg_c1", dut.shift_reg, 4'b0000);
    chk("rst_out_c1", {3'b0, out4}, 4'b0000);

    // Release on a negedge together with the first pattern bit.
    @(negedge clk);
    rst = 1'b1;
    serial_in = pat_bits[0];
    @(posedge clk); #1;
    chk("pat_reg_0", dut.shift_reg, pat_reg[0]);
    chk("pat_out_0", {3'b0, out4}, {3'b0, pat_out[0]});
    chk("n1_out_0", {3'b0, out1}, {3'b0, pat_bits[0]});
    for (int i = 1; i < 4; i++) begin
      step(pat_bits[i]);
      chk("pat_reg", dut.shift_reg, pat_reg[i]);
      chk("pat_out", {3'b0, out4}, {3'b0, pat_out[i]});
      chk("n1_out", {3'b0, out1}, {3'b0, pat_bits[i]});
    end

    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      chk("flush_reg", dut.shift_reg, fl_reg[i]);
      chk("flush_out", {3'b0, out4}, {3'b0, fl_out[i]});
    end

    // Load all ones, then assert reset between clock edges.
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("load_ones", dut.shift_reg, 4'b1111);
    chk("load_out", {3'b0, out4}, 4'b0001);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reg", dut.shift_reg, 4'b0000);
    chk("async_out", {3'b0, out4}, 4'b0000);
    chk("async_reg1", {3'b0, dut1.shift_reg}, 4'b0000);
    @(posedge clk); #1;
    chk("rst_hold_reg", dut.shift_reg, 4'b0000);

    // Single-cycle pulse; it must appear once, on the fourth edge after being driven.
    @(negedge clk);
    rst = 1'b1;
    serial_in = 1'b1;
    @(posedge clk); #1;
    chk("lat_out_0", {3'b0, out4}, {3'b0, lat_out[0]});
    chk("lat_out1_0", {3'b0, out1}, 4'b0001);
    for (int i = 1; i < 7; i++) begin
      step(1'b0);
      chk("lat_out", {3'b0, out4}, {3'b0, lat_out[i]});
    end
    chk("lat_reg_end", dut.shift_reg, 4'b0000);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
